fifo_burst_reader: RTL

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

---
 rtl/fifo_burst_reader_if.sv | 31 +++
 rtl/fifo_burst_reader.sv | 85 ++++++++
 2 files changed

// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle for fifo_burst_reader: burst control, FIFO read port and downstream stream.
// The master view belongs to the reader; the slave view to whatever drives it.
interface fifo_burst_reader_if #(
   parameter int unsigned DataWidth = 8,
   parameter int unsigned MaxBurst  = 16
);
   localparam int unsigned LenW = $clog2(MaxBurst + 1);

   logic                 start_i;
   logic [LenW-1:0]      len_i;
   logic                 busy_o;
   logic                 done_o;
   logic [LenW-1:0]      count_o;
   logic                 fifo_rvalid_i;
   logic                 fifo_rready_o;
   logic [DataWidth-1:0] fifo_data_i;
   logic                 m_valid_o;
   logic                 m_ready_i;
   logic [DataWidth-1:0] m_data_o;
   logic                 m_last_o;

   modport master (
      input  start_i, len_i, fifo_rvalid_i, fifo_data_i, m_ready_i,
      output busy_o, done_o, count_o, fifo_rready_o, m_valid_o, m_data_o, m_last_o
   );

   modport slave (
      output start_i, len_i, fifo_rvalid_i, fifo_data_i, m_ready_i,
      input  busy_o, done_o, count_o, fifo_rready_o, m_valid_o, m_data_o, m_last_o
   );
endinterface

// File: rtl/fifo_burst_reader.sv
// Pops a burst of up to MaxBurst words from a FIFO read port and forwards them
// through a one-deep output register with last-word marking and a done pulse.
module fifo_burst_reader #(
   parameter int unsigned DataWidth = 8,
   parameter int unsigned MaxBurst  = 16
) (
   input  logic                clk_i,
   input  logic                reset_i,
   fifo_burst_reader_if.master bus
);
   localparam int unsigned LenW = $clog2(MaxBurst + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state;
   logic [LenW-1:0]      len_q;
   logic [LenW-1:0]      fetched_q;
   logic [LenW-1:0]      count_q;
   logic                 m_valid_q;
   logic                 m_last_q;
   logic [DataWidth-1:0] m_data_q;
   logic                 rready;
   logic                 pop;
   logic                 accept;

   // Gated by reset so no pop can be requested while the burst is being abandoned.
   always_comb begin
      rready = !reset_i && (state == RUN) && (fetched_q < len_q) &&
               (!m_valid_q || bus.m_ready_i);
      pop    = rready && bus.fifo_rvalid_i;
      accept = m_valid_q && bus.m_ready_i;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state     <= IDLE;
         len_q     <= '0;
         fetched_q <= '0;
         count_q   <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_data_q  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start_i) begin
                  count_q   <= '0;
                  fetched_q <= '0;
                  if (bus.len_i == '0) begin
                     state <= DONE;
                  end else begin
                     len_q <= (bus.len_i > LenW'(MaxBurst)) ? LenW'(MaxBurst) : bus.len_i;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (accept) begin
                  count_q   <= count_q + LenW'(1);
                  m_valid_q <= 1'b0;
                  m_last_q  <= 1'b0;
                  if (m_last_q) state <= DONE;
               end
               // A pop in the same cycle as an accept reloads the output register.
               if (pop) begin
                  fetched_q <= fetched_q + LenW'(1);
                  m_valid_q <= 1'b1;
                  m_data_q  <= bus.fifo_data_i;
                  m_last_q  <= (fetched_q + LenW'(1) == len_q);
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy_o        = (state != IDLE);
   assign bus.done_o        = (state == DONE);
   assign bus.count_o       = count_q;
   assign bus.fifo_rready_o = rready;
   assign bus.m_valid_o     = m_valid_q;
   assign bus.m_data_o      = m_data_q;
   assign bus.m_last_o      = m_last_q;
endmodule
